// File: rtl/uart_rx_fifo_if.sv
// Consumer-side handshake of the UART receiver: head-of-FIFO entry, status
// flags and sticky overrun, with a single ready back from the consumer.
interface uart_rx_fifo_if;
   logic       o_valid;
   logic       i_ready;
   logic [7:0] o_data;
   logic       o_parity_err;
   logic       o_frame_err;
   logic       o_break;
   logic       o_overrun;

   modport master (output o_valid, o_data, o_parity_err, o_frame_err, o_break, o_overrun,
                   input  i_ready);
   modport slave  (input  o_valid, o_data, o_parity_err, o_frame_err, o_break, o_overrun,
                   output i_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime frame format and divisor, feeding a small FIFO of
// {break, frame_err, parity_err, data} entries drained by a valid/ready consumer.
module uart_rx_fifo #(
   parameter int TIMER_BITS = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  i_reset,
   input  logic [TIMER_BITS-1:0] i_clocks_per_baud,
   input  logic [1:0]            i_data_bits,
   input  logic [1:0]            i_parity,
   input  logic                  i_stop_bits,
   input  logic                  uart_txd_in,
   uart_rx_fifo_if.master        rx
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [TIMER_BITS-1:0] ONE  = TIMER_BITS'(1);
   localparam logic [TIMER_BITS-1:0] FOUR = TIMER_BITS'(4);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

   state_t state, state_n;

   logic [2:0]            sync_q;
   logic                  rx_s, prev_rx, fall;
   logic [TIMER_BITS-1:0] cnt, n_lat, n_eff;
   logic                  tick;
   logic [2:0]            last_idx, bit_idx;
   logic [1:0]            par_lat;
   logic                  par_en, stop2_lat, stop_idx;
   logic [7:0]            data_q;
   logic                  low_q, brk_q, ferr_q, par_bit_q;
   logic                  start_frame, timing, smp_data, smp_par, smp_stop, push;
   logic                  brk_now, ferr_now, perr_now, par_x;

   assign rx_s   = sync_q[2];
   assign fall   = prev_rx & ~rx_s;
   assign tick   = (cnt == '0);
   assign par_en = (par_lat == 2'b01) || (par_lat == 2'b10);
   assign n_eff  = (i_clocks_per_baud < FOUR) ? FOUR : i_clocks_per_baud;

   // Syncs clear to 0 so a line already low at reset release never looks like an edge.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         sync_q  <= '0;
         prev_rx <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], uart_txd_in};
         prev_rx <= rx_s;
      end
   end

   always_ff @(posedge clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:      if (fall) state_n = START;
         START:     if (tick) state_n = rx_s ? IDLE : DATA;
         DATA:      if (tick && bit_idx == last_idx) state_n = par_en ? PARITY : STOP;
         PARITY:    if (tick) state_n = STOP;
         STOP:      if (tick && stop_idx == stop2_lat) state_n = rx_s ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (rx_s) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   always_comb begin
      start_frame = 1'b0;
      timing      = 1'b0;
      smp_data    = 1'b0;
      smp_par     = 1'b0;
      smp_stop    = 1'b0;
      unique case (state)
         IDLE:    start_frame = fall;
         START:   timing = 1'b1;
         DATA:    begin timing = 1'b1; smp_data = tick; end
         PARITY:  begin timing = 1'b1; smp_par  = tick; end
         STOP:    begin timing = 1'b1; smp_stop = tick; end
         default: ;
      endcase
   end

   assign push     = smp_stop && (stop_idx == stop2_lat);
   assign brk_now  = (stop_idx == 1'b0) ? (low_q & ~rx_s) : brk_q;
   assign ferr_now = ferr_q | ~rx_s;
   assign par_x    = (^data_q) ^ par_bit_q;
   assign perr_now = (par_lat == 2'b01) ? par_x : (par_lat == 2'b10) ? ~par_x : 1'b0;

   always_ff @(posedge clk) begin
      if (i_reset) begin
         cnt       <= '0;
         n_lat     <= '0;
         last_idx  <= '0;
         par_lat   <= '0;
         stop2_lat <= 1'b0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         data_q    <= '0;
         low_q     <= 1'b0;
         brk_q     <= 1'b0;
         ferr_q    <= 1'b0;
         par_bit_q <= 1'b0;
      end else if (start_frame) begin
         // First sample lands H cycles after the edge cycle, hence H-1 here.
         cnt       <= (n_eff >> 1) - ONE;
         n_lat     <= n_eff;
         last_idx  <= {1'b1, i_data_bits};
         par_lat   <= i_parity;
         stop2_lat <= i_stop_bits;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         data_q    <= '0;
         low_q     <= 1'b1;
         brk_q     <= 1'b0;
         ferr_q    <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         if (timing) cnt <= tick ? (n_lat - ONE) : (cnt - ONE);
         if (smp_data) begin
            data_q[bit_idx] <= rx_s;
            bit_idx         <= bit_idx + 3'd1;
            low_q           <= low_q & ~rx_s;
         end
         if (smp_par) begin
            par_bit_q <= rx_s;
            low_q     <= low_q & ~rx_s;
         end
         if (smp_stop) begin
            stop_idx <= 1'b1;
            ferr_q   <= ferr_now;
            if (stop_idx == 1'b0) brk_q <= brk_now;
         end
      end
   end

   // Receive FIFO: combinational head read, outputs gated to zero when empty.
   logic [10:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic          valid, full, pop, wr_en, overrun;
   logic [10:0]   head;

   assign valid = (count != '0);
   assign full  = (count == DEPTH_C);
   assign pop   = valid && rx.i_ready;
   assign wr_en = push && (!full || pop);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {brk_now, ferr_now, perr_now, data_q};
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (pop)   rd_ptr <= rd_ptr + PW'(1);
         if (wr_en && !pop)      count <= count + (PW+1)'(1);
         else if (!wr_en && pop) count <= count - (PW+1)'(1);
         if (push && full && !pop) overrun <= 1'b1;
      end
   end

   assign rx.o_valid      = valid;
   assign rx.o_data       = valid ? head[7:0] : 8'h00;
   assign rx.o_parity_err = valid & head[8];
   assign rx.o_frame_err  = valid & head[9];
   assign rx.o_break      = valid & head[10];
   assign rx.o_overrun    = overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: frames are built bit by bit from the format rules, the
// expected entry is queued at send time and a negedge monitor checks each pop.
module tb_uart_rx_fifo;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic       brk;
      logic       ferr;
      logic       perr;
      logic [7:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] cpb = 24'd16;
   logic [1:0]  dbits = 2'b11;
   logic [1:0]  par = 2'b00;
   logic        stop2 = 1'b0;
   logic        line = 1'b1;
   logic        rdy_fix = 1'b1;
   logic        rdy_rnd = 1'b0;
   logic        rand_ready = 1'b0;

   ent_t exp_q[$];
   ent_t mon_e;
   logic exp_ovr = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   uart_rx_fifo_if rx();
   assign rx.i_ready = rand_ready ? rdy_rnd : rdy_fix;

   uart_rx_fifo #(.TIMER_BITS(24), .FIFO_DEPTH(DEPTH)) dut (
      .clk               (clk),
      .i_reset           (rst),
      .i_clocks_per_baud (cpb),
      .i_data_bits       (dbits),
      .i_parity          (par),
      .i_stop_bits       (stop2),
      .uart_txd_in       (line),
      .rx                (rx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rdy_rnd <= 1'($urandom_range(0, 1));

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
   endtask

   always @(negedge clk) begin
      if (!rst && rx.o_valid && rx.i_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_entry: got %0h expected none",
                     {rx.o_break, rx.o_frame_err, rx.o_parity_err, rx.o_data});
         end else begin
            mon_e = exp_q.pop_front();
            chk("entry", 32'({rx.o_break, rx.o_frame_err, rx.o_parity_err, rx.o_data}),
                32'(mon_e));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int nper();
      return (cpb < 24'd4) ? 4 : int'(cpb);
   endfunction

   task automatic send_frame(input logic [7:0] d, input bit flip, input bit s1, input bit s2);
      int         nb;
      int         np;
      bit         pe;
      logic [7:0] dm;
      logic [7:0] mask;
      logic       p;
      ent_t       e;
      nb   = int'(dbits) + 5;
      np   = nper();
      pe   = (par == 2'b01) || (par == 2'b10);
      mask = 8'((16'd1 << nb) - 16'd1);
      dm   = d & mask;
      p    = (par == 2'b10) ? ~(^dm) : (^dm);
      if (flip) p = ~p;
      e.d    = dm;
      e.perr = (par == 2'b01) ? ((^dm) ^ p) : (par == 2'b10) ? ~((^dm) ^ p) : 1'b0;
      e.ferr = !s1 || (stop2 && !s2);
      e.brk  = (dm == 8'h00) && (!pe || !p) && !s1;
      if (exp_q.size() >= DEPTH) exp_ovr = 1'b1;
      else exp_q.push_back(e);
      line = 1'b0; tick(np);
      for (int i = 0; i < nb; i++) begin
         line = dm[i]; tick(np);
      end
      if (pe) begin line = p; tick(np); end
      line = s1; tick(np);
      if (stop2) begin line = s2; tick(np); end
      line = 1'b1; tick(2 * np);
   endtask

   task automatic drain(input string nm);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 3000) begin
         tick(1);
         k++;
      end
      chk(nm, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic reset_pulse(input int n);
      rst = 1'b1; tick(n); rst = 1'b0;
   endtask

   initial begin
      ent_t e;
      tick(5);
      chk("rst_valid", 32'(rx.o_valid), 32'd0);
      chk("rst_data", 32'(rx.o_data), 32'd0);
      chk("rst_perr", 32'(rx.o_parity_err), 32'd0);
      chk("rst_ferr", 32'(rx.o_frame_err), 32'd0);
      chk("rst_brk", 32'(rx.o_break), 32'd0);
      chk("rst_ovr", 32'(rx.o_overrun), 32'd0);
      rst = 1'b0;
      tick(20);

      // 8N1 0xA5
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      drain("drain_8n1");

      // 7E1 0x41 with the parity bit inverted
      dbits = 2'b10; par = 2'b01;
      send_frame(8'h41, 1'b1, 1'b1, 1'b1);
      drain("drain_7e1");

      // Line held low for 12 bit times: a single break entry
      dbits = 2'b11; par = 2'b00;
      e.brk = 1'b1; e.ferr = 1'b1; e.perr = 1'b0; e.d = 8'h00;
      exp_q.push_back(e);
      line = 1'b0; tick(12 * 16);
      line = 1'b1; tick(64);
      drain("drain_break");
      chk("break_single", 32'(rx.o_valid), 32'd0);

      // Short glitch must not produce anything and must leave the receiver usable
      line = 1'b0; tick(3);
      line = 1'b1; tick(64);
      chk("glitch_none", 32'(rx.o_valid), 32'd0);
      send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
      drain("drain_after_glitch");

      // Reset during data bit 3 with the line low through release
      line = 1'b0; tick(16 + 3 * 16 + 8);
      reset_pulse(2);
      tick(40);
      line = 1'b1; tick(64);
      chk("rst_abort_none", 32'(rx.o_valid), 32'd0);
      send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
      drain("drain_after_reset");

      // Overrun: five bytes into a four-entry FIFO with the consumer stalled
      rdy_fix = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b1);
      chk("ovr_set", 32'(rx.o_overrun), 32'(exp_ovr));
      chk("ovr_valid", 32'(rx.o_valid), 32'd1);
      chk("ovr_head", 32'(rx.o_data), 32'h01);
      rdy_fix = 1'b1;
      drain("drain_ovr");
      chk("ovr_sticky", 32'(rx.o_overrun), 32'(exp_ovr));
      reset_pulse(2);
      exp_ovr = 1'b0;
      tick(1);
      chk("ovr_cleared", 32'(rx.o_overrun), 32'(exp_ovr));
      tick(20);

      // Divisor below 4, odd parity, two stop bits
      cpb = 24'd2; par = 2'b10; stop2 = 1'b1;
      send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
      drain("drain_small_n");

      // Randomised formats, errors and consumer back-pressure
      rand_ready = 1'b1;
      for (int f = 0; f < 16; f++) begin
         cpb   = 24'($urandom_range(2, 20));
         dbits = 2'($urandom_range(0, 3));
         par   = 2'($urandom_range(0, 3));
         stop2 = 1'($urandom_range(0, 1));
         send_frame(($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 5) != 0),
                    ($urandom_range(0, 5) != 0));
      end
      drain("drain_random");
      rand_ready = 1'b0;
      chk("final_ovr", 32'(rx.o_overrun), 32'(exp_ovr));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
